// File: rtl/reg_enable_sequencer_if.sv
// Request/enable bus between the control unit (master) and reg_enable_sequencer (slave).
interface reg_enable_sequencer_if #(
    parameter int unsigned ADDR_W = 3
);
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic                req_valid;
    logic                req_ready;
    logic                req_mode;
    logic [ADDR_W-1:0]   req_addr;
    logic [ADDR_W:0]     req_len;
    logic                abort;
    logic [NUM_REGS-1:0] en;
    logic [ADDR_W-1:0]   cur_addr;
    logic                busy;
    logic                done;

    modport master (
        output req_valid, req_mode, req_addr, req_len, abort,
        input  req_ready, en, cur_addr, busy, done
    );

    modport slave (
        input  req_valid, req_mode, req_addr, req_len, abort,
        output req_ready, en, cur_addr, busy, done
    );
endinterface

// File: rtl/reg_enable_sequencer.sv
// Register-file write-enable sequencer: single or sweep requests become a registered one-hot enable.
// Optional macro REG_ZERO_PROTECT_EN suppresses the enable bit of register 0 (hardwired-zero register).
module reg_enable_sequencer #(
    parameter int unsigned ADDR_W    = 3,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                   clock,
    input  logic                   resetn,
    reg_enable_sequencer_if.slave  bus
);
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam int unsigned REM_W    = ADDR_W + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [NUM_REGS-1:0] en_q, en_d;

    logic last;
    logic ready;
    logic accept;

    // One-hot decode; for a power-of-two register count NUM_REGS-1-a is simply ~a.
    function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0]   bit_idx;
        logic [NUM_REGS-1:0] onehot;
        bit_idx         = MSB_FIRST ? ~a : a;
        onehot          = '0;
        onehot[bit_idx] = 1'b1;
`ifdef REG_ZERO_PROTECT_EN
        if (a == '0) begin
            onehot = '0;
        end
`endif
        return onehot;
    endfunction

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            cur_addr_q <= '0;
            en_q       <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            cur_addr_q <= cur_addr_d;
            en_q       <= en_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        cur_addr_d = cur_addr_q;
        en_d       = '0;

        last   = (state_q == ACTIVE) && (rem_q == REM_W'(1));
        ready  = !bus.abort && ((state_q == IDLE) || last);
        accept = bus.req_valid && ready;

        if (bus.abort) begin
            state_d = IDLE;
            rem_d   = '0;
        end else if (accept) begin
            // Accepting on the last cycle chains straight into the new operation.
            state_d    = ACTIVE;
            cur_addr_d = bus.req_addr;
            if (!bus.req_mode) begin
                rem_d = REM_W'(1);
            end else if (bus.req_len == '0) begin
                rem_d = REM_W'(NUM_REGS);
            end else begin
                rem_d = bus.req_len;
            end
        end else if (state_q == ACTIVE) begin
            if (last) begin
                state_d = IDLE;
                rem_d   = '0;
            end else begin
                cur_addr_d = cur_addr_q + ADDR_W'(1);
                rem_d      = rem_q - REM_W'(1);
            end
        end

        if (state_d == ACTIVE) begin
            en_d = decode(cur_addr_d);
        end
    end

    assign bus.req_ready = ready;
    assign bus.en        = en_q;
    assign bus.cur_addr  = cur_addr_q;
    assign bus.busy      = (state_q == ACTIVE);
    assign bus.done      = last;

endmodule

// File: tb/tb_reg_enable_sequencer.sv
// Directed plus randomized checking of reg_enable_sequencer against a queue-based schedule model.
module tb_reg_enable_sequencer;
    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    // Model: ordered list of register addresses still to be enabled; head is the current cycle.
    int   sched[$];
    logic ready_exp;

`ifdef REG_ZERO_PROTECT_EN
    localparam logic [7:0] EN_R0 = 8'h00;
`else
    localparam logic [7:0] EN_R0 = 8'h80;
`endif

    reg_enable_sequencer_if #(.ADDR_W(3)) bus ();

    reg_enable_sequencer #(
        .ADDR_W   (3),
        .MSB_FIRST(1'b1)
    ) dut (
        .clock (clk),
        .resetn(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_en(input int a);
`ifdef REG_ZERO_PROTECT_EN
        if (a == 0) return 8'h00;
`endif
        return 8'(2 ** (7 - a));
    endfunction

    task automatic check_outputs();
        logic [7:0] en_exp;
        en_exp = (sched.size() > 0) ? model_en(sched[0]) : 8'h00;
        check_eq("en", 32'(bus.en), 32'(en_exp));
        check_eq("busy", 32'(bus.busy), 32'(sched.size() > 0));
        check_eq("done", 32'(bus.done), 32'(sched.size() == 1));
        if (sched.size() > 0) begin
            check_eq("cur_addr", 32'(bus.cur_addr), 32'(sched[0]));
        end
    endtask

    // One clock: drive inputs, check ready, advance the model across the edge, check outputs.
    task automatic step(input logic v, input logic m, input logic [2:0] a,
                        input logic [3:0] l, input logic ab);
        int n;
        bit acc;
        bus.req_valid = v;
        bus.req_mode  = m;
        bus.req_addr  = a;
        bus.req_len   = l;
        bus.abort     = ab;
        #1;
        ready_exp = !ab && (sched.size() <= 1);
        check_eq("req_ready", 32'(bus.req_ready), 32'(ready_exp));
        acc = v && ready_exp;
        @(posedge clk);
        if (ab) begin
            sched.delete();
        end else begin
            if (sched.size() > 0) void'(sched.pop_front());
            if (acc) begin
                n = m ? ((l == 4'd0) ? 8 : int'(l)) : 1;
                for (int i = 0; i < n; i++) sched.push_back((int'(a) + i) % 8);
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_mode  = 1'b0;
        bus.req_addr  = 3'd0;
        bus.req_len   = 4'd0;
        bus.abort     = 1'b0;
    endtask

    // Asynchronous reset between edges: outputs must clear without waiting for a clock.
    task automatic reset_pulse();
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_en", 32'(bus.en), 32'h0);
        check_eq("rst_busy", 32'(bus.busy), 32'h0);
        check_eq("rst_done", 32'(bus.done), 32'h0);
        sched.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        bus.req_valid = 1'b1;

        // Reset held with a pending request
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t1_en", 32'(bus.en), 32'h0);
            check_eq("t1_busy", 32'(bus.busy), 32'h0);
            check_eq("t1_done", 32'(bus.done), 32'h0);
        end
        rst_n = 1'b1;
        #1;
        check_eq("t1_ready", 32'(bus.req_ready), 32'h1);
        check_eq("t1_en_rel", 32'(bus.en), 32'h0);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;

        // Single request
        step(1'b1, 1'b0, 3'd3, 4'd0, 1'b0);
        check_eq("t2_en", 32'(bus.en), 32'h10);
        check_eq("t2_done", 32'(bus.done), 32'h1);
        step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        check_eq("t2_en_off", 32'(bus.en), 32'h0);

        // Back-to-back singles
        step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
        check_eq("t3_en0", 32'(bus.en), 32'(EN_R0));
        step(1'b1, 1'b0, 3'd7, 4'd0, 1'b0);
        check_eq("t3_en7", 32'(bus.en), 32'h01);
        step(1'b1, 1'b0, 3'd2, 4'd0, 1'b0);
        check_eq("t3_en2", 32'(bus.en), 32'h20);
        step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);

        // Wrapping sweep
        step(1'b1, 1'b1, 3'd6, 4'd4, 1'b0);
        check_eq("t4_en_a", 32'(bus.en), 32'h02);
        step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        check_eq("t4_en_b", 32'(bus.en), 32'h01);
        step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        check_eq("t4_en_c", 32'(bus.en), 32'h80);
        check_eq("t4_done_c", 32'(bus.done), 32'h0);
        check_eq("t4_ready_c", 32'(bus.req_ready), 32'h0);
        step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        check_eq("t4_en_d", 32'(bus.en), 32'h40);
        check_eq("t4_done_d", 32'(bus.done), 32'h1);
        check_eq("t4_ready_d", 32'(bus.req_ready), 32'h1);
        step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);

        // Full sweep, len = 0
        step(1'b1, 1'b1, 3'd0, 4'd0, 1'b0);
        check_eq("t5_en0", 32'(bus.en), 32'(EN_R0));
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
            check_eq("t5_en", 32'(bus.en), 32'(8'h80 >> i));
        end
        step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);

        // Abort on the third enable cycle
        step(1'b1, 1'b1, 3'd0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        check_eq("t5_en3", 32'(bus.en), 32'h20);
        step(1'b0, 1'b0, 3'd0, 4'd0, 1'b1);
        check_eq("t5_ab_en", 32'(bus.en), 32'h0);
        check_eq("t5_ab_busy", 32'(bus.busy), 32'h0);
        check_eq("t5_ab_done", 32'(bus.done), 32'h0);
        // A request alongside abort is refused
        step(1'b1, 1'b0, 3'd3, 4'd0, 1'b1);
        check_eq("t5_ab_req", 32'(bus.en), 32'h0);

        // Reset mid-sweep
        step(1'b1, 1'b1, 3'd0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        reset_pulse();

`ifdef REG_ZERO_PROTECT_EN
        step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
        check_eq("t6_en0", 32'(bus.en), 32'h0);
        check_eq("t6_done0", 32'(bus.done), 32'h1);
        step(1'b1, 1'b1, 3'd7, 4'd2, 1'b0);
        check_eq("t6_en7", 32'(bus.en), 32'h01);
        step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        check_eq("t6_en0s", 32'(bus.en), 32'h0);
        check_eq("t6_done", 32'(bus.done), 32'h1);
        step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
`endif

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset_pulse();
            end else begin
                step(1'($urandom_range(0, 9) < 6),
                     1'($urandom_range(0, 1)),
                     3'($urandom_range(0, 7)),
                     4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 19) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/reg_enable_sequencer.md
Name: reg_enable_sequencer

Overview:
- Parametrised successor to the register-file write-enable decoder.
- Converts a register address into a registered one-hot write-enable vector.
- Adds a valid/ready request handshake, a multi-register sweep mode (used to clear or bulk-load the register file) and a synchronous abort.
- Sits between the control unit and the register file write ports.

Parameters:
- ADDR_W, 3: register address width; NUM_REGS = 2**ADDR_W (derived localparam).
- MSB_FIRST, 1: 1 = register 0 drives en[NUM_REGS-1] (legacy ordering); 0 = register 0 drives en[0].

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_mode  in  1  0 = single register, 1 = sweep.
- req_addr  in  ADDR_W  target register (single) or start register (sweep).
- req_len  in  ADDR_W+1  sweep length; ignored in single mode.
- abort  in  1  synchronous cancel of the current operation.
- en  out  NUM_REGS  registered one-hot write enable; all-zero when idle.
- cur_addr  out  ADDR_W  address currently enabled.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse on the final enable cycle.

Behaviour:
- Reset (resetn low, asynchronous):
  - en = 0, cur_addr = 0, busy = 0, done = 0, state = IDLE.
  - req_ready = 1 once resetn is high.
- States: IDLE and ACTIVE, with an internal counter rem of width ADDR_W+1.
- Request acceptance: a request is accepted on a rising edge when req_valid & req_ready.
- Latency: en for the first register is asserted in the cycle after acceptance.
- Single mode: rem = 1, so en is asserted for exactly one cycle.
- Sweep mode:
  - rem = req_len; req_len = 0 means NUM_REGS.
  - Each ACTIVE cycle enables cur_addr, then cur_addr increments modulo NUM_REGS (wraps 7 -> 0 when ADDR_W = 3) and rem decrements.
- last = ACTIVE & (rem == 1).
- done = last. done is combinational from registered state and aligned with the final en.
- req_ready = IDLE | last. This allows back-to-back requests with no bubble:
  - A request accepted during the last cycle starts ACTIVE on the next cycle.
  - Otherwise the block returns to IDLE.
- busy = ACTIVE.
- en is strictly one-hot in ACTIVE and zero in IDLE. en is driven from a flop, not decoded combinationally from the inputs.
- Address decode with MSB_FIRST = 1: en = 1 << (NUM_REGS-1-cur_addr).
- Address decode with MSB_FIRST = 0: en = 1 << cur_addr.
- abort:
  - Highest priority; state goes to IDLE on the next edge and en goes to 0.
  - No done is generated for an aborted operation.
  - A request presented in the same cycle as abort is not accepted; req_ready is forced to 0 while abort = 1.
- resetn asserted mid-operation: outputs clear immediately and the operation is lost.
- req_addr, req_mode and req_len are sampled only at acceptance; later changes have no effect.

Optional Feature:
- Macro: REG_ZERO_PROTECT_EN.
- Defined:
  - The en bit for register 0 is never asserted, giving a hardwired-zero register.
  - A single request to register 0 still consumes one ACTIVE cycle and still pulses done, with en = 0.
  - A sweep crossing register 0 spends its cycle on it with en = 0.
- Undefined: register 0 is enabled like any other register.

Test Plan (ADDR_W = 3, MSB_FIRST = 1):
1. Reset: hold resetn low with req_valid = 1 -> en = 8'h00, busy = 0, done = 0 throughout. After release, req_ready = 1 and en = 8'h00.
2. Single request, req_addr = 3, accepted at cycle T -> en = 8'h10 at T+1 only, done = 1 at T+1, en = 8'h00 at T+2.
3. Back-to-back singles to addresses 0, 7, 2 on consecutive cycles with req_valid held high -> en = 8'h80, 8'h01, 8'h20 on three consecutive cycles, with no idle gap.
4. Sweep, req_addr = 6, req_len = 4 -> en = 8'h02, 8'h01, 8'h80, 8'h40 on four consecutive cycles (wraps). done and req_ready are high on the 4th cycle only.
5. Sweep with req_len = 0 from address 0:
   - Without interruption -> 8 enables, 8'h80 through 8'h01.
   - Repeat with abort = 1 during the 3rd enable cycle -> en = 8'h00 the next cycle, no done, busy = 0.
   - Repeat with resetn pulsed low mid-sweep -> en clears asynchronously.
6. With REG_ZERO_PROTECT_EN defined:
   - Single request to address 0 -> en stays 8'h00 and done pulses.
   - Sweep from address 7 with req_len = 2 -> en = 8'h01, then 8'h00, with done on the second cycle.
